// File: rtl/frame_arb_pkg.sv
// Shared types and default sizing for the frame round-robin arbiter.
package frame_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PASS = 1'b1
   } state_t;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_NUM_CH     = 2;
   localparam int DEF_BLOCK_SIZE = 256;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requesting channel at or after ptr,
// wrapping past NUM_CH-1 back to channel 0.
module rr_pick #(
   parameter int NUM_CH = 2
) (
   input  logic [NUM_CH-1:0]         req,
   input  logic [$clog2(NUM_CH)-1:0] ptr,
   output logic [$clog2(NUM_CH)-1:0] idx,
   output logic                      any
);

   localparam int IW = $clog2(NUM_CH);

   int                c;
   logic [NUM_CH-1:0] sel;

   always_comb begin
      idx = '0;
      any = 1'b0;
      c   = 0;
      sel = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         c = int'(ptr) + k;
         if (c >= NUM_CH) c = c - NUM_CH;
         sel = NUM_CH'(1) << c;
         if (!any && (|(req & sel))) begin
            any = 1'b1;
            idx = IW'(c);
         end
      end
   end

endmodule

// File: rtl/frame_rr_arbiter.sv
// Block-granular round-robin arbiter: one channel owns the link for a whole
// interleaved block, with sof/eof framing for the downstream sync inserter.
module frame_rr_arbiter
   import frame_arb_pkg::*;
#(
   parameter int DATA_WIDTH          = DEF_DATA_WIDTH,
   parameter int NUM_CH              = DEF_NUM_CH,
   parameter int BLOCK_SIZE_IN_WORDS = DEF_BLOCK_SIZE
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
   input  logic [NUM_CH-1:0]            valid_in,
   output logic [NUM_CH-1:0]            ready_out,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         valid_out,
   input  logic                         ready_in,
   output logic                         sof_out,
   output logic                         eof_out,
   output logic [$clog2(NUM_CH)-1:0]    grant_ch
);

   localparam int             GW        = $clog2(NUM_CH);
   localparam int             CW        = $clog2(BLOCK_SIZE_IN_WORDS);
   localparam logic [CW-1:0]  LAST_WORD = CW'(BLOCK_SIZE_IN_WORDS - 1);
   localparam logic [GW-1:0]  LAST_CH   = GW'(NUM_CH - 1);

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [GW-1:0]     grant, grant_nxt;
   logic [GW-1:0]     last_grant, last_grant_nxt;

   logic [NUM_CH-1:0] grant_mask;
   logic [NUM_CH-1:0] pick_req;
   logic [GW-1:0]     pick_ptr, pick_idx;
   logic              pick_any;
   logic              xfer, block_end;

   function automatic logic [GW-1:0] next_ch(input logic [GW-1:0] ch);
      return (ch == LAST_CH) ? '0 : ch + GW'(1);
   endfunction

   assign grant_mask = NUM_CH'(1) << grant;
   assign xfer       = valid_out & ready_in;
   assign block_end  = (cnt == LAST_WORD);
   assign grant_ch   = grant;

   // At a block boundary the finishing channel is masked out, so it only
   // wins again (via IDLE) when nobody else is asking.
   assign pick_req = (state == PASS) ? (valid_in & ~grant_mask) : valid_in;
   assign pick_ptr = next_ch((state == PASS) ? grant : last_grant);

   rr_pick #(.NUM_CH(NUM_CH)) u_pick (
      .req (pick_req),
      .ptr (pick_ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      data_out  = '0;
      valid_out = 1'b0;
      ready_out = '0;
      sof_out   = 1'b0;
      eof_out   = 1'b0;
      if (state == PASS) begin
         data_out  = DATA_WIDTH'(data_in >> (grant * DATA_WIDTH));
         valid_out = valid_in[grant];
         ready_out = ready_in ? grant_mask : '0;
         sof_out   = valid_out & (cnt == '0);
         eof_out   = valid_out & block_end;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_nxt = PASS;
               grant_nxt = pick_idx;
            end
         end
         PASS: begin
            if (xfer) begin
               if (block_end) begin
                  cnt_nxt        = '0;
                  last_grant_nxt = grant;
                  if (pick_any) grant_nxt = pick_idx;
                  else          state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         grant      <= '0;
         last_grant <= LAST_CH;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
      end
   end

endmodule
